// File: rtl/drum_host_sequencer.sv
// drum_host_sequencer: host bus initiator for the DRUM multiplier tile.
// Writes A/B, reads back the 16-bit product, returns it on a valid/ready port.
module drum_host_sequencer #(
  parameter int         SETTLE_CYCLES = 8,
  parameter logic [4:0] RES_LO_ADDR   = 5'd14,
  parameter logic [4:0] RES_HI_ADDR   = 5'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_r,
  output logic [15:0] op_count,
  output logic [7:0]  dut_ui,
  output logic [7:0]  dut_uio,
  input  logic [7:0]  dut_uo
);

  localparam logic [7:0] UI_IDLE = 8'h10;
  localparam logic [7:0] UI_WR_A = 8'h80;
  localparam logic [7:0] UI_WR_B = 8'h81;
  localparam int         CW      = 16;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_WR_A,
    S_WR_B,
    S_WAIT,
    S_RD_LO,
    S_RD_HI,
    S_CAP,
    S_RESP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] settle_q;
  logic [7:0]    b_q;
  logic [7:0]    ui_q;
  logic [7:0]    uio_q;
  logic          ready_q;
  logic          valid_q;
  logic [15:0]   rsp_q;
  logic [15:0]   ops_q;

  // Sequencer FSM; bus outputs are registered for the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_INIT;
      settle_q <= SETTLE_LOAD;
      b_q      <= '0;
      ui_q     <= UI_IDLE;
      uio_q    <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      rsp_q    <= '0;
      ops_q    <= '0;
    end else begin
      ui_q  <= UI_IDLE;
      uio_q <= '0;
      unique case (state_q)
        S_INIT: begin
          if (settle_q == '0) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid && ready_q) begin
            b_q     <= req_b;
            ready_q <= 1'b0;
            ui_q    <= UI_WR_A;
            uio_q   <= req_a;
            state_q <= S_WR_A;
          end
        end
        S_WR_A: begin
          ui_q    <= UI_WR_B;
          uio_q   <= b_q;
          state_q <= S_WR_B;
        end
        S_WR_B: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          ui_q    <= {3'b000, RES_LO_ADDR};
          state_q <= S_RD_LO;
        end
        S_RD_LO: begin
          ui_q    <= {3'b000, RES_HI_ADDR};
          state_q <= S_RD_HI;
        end
        S_RD_HI: begin
          rsp_q[7:0] <= dut_uo;
          state_q    <= S_CAP;
        end
        S_CAP: begin
          rsp_q[15:8] <= dut_uo;
          valid_q     <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            ops_q   <= ops_q + 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_r     = rsp_q;
  assign op_count  = ops_q;
  assign dut_ui    = ui_q;
  assign dut_uio   = uio_q;

endmodule

// File: tb/tb_drum_host_sequencer.sv
// tb_drum_host_sequencer: directed bench with a behavioural tile model
// and a queue of expected products popped at each response handshake.
module tb_drum_host_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_r;
  logic [15:0] op_count;
  logic [7:0]  dut_ui;
  logic [7:0]  dut_uio;
  logic [7:0]  dut_uo;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  drum_host_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_r     (rsp_r),
    .op_count  (op_count),
    .dut_ui    (dut_ui),
    .dut_uio   (dut_uio),
    .dut_uo    (dut_uo)
  );

  always #5 clk = ~clk;

  // Tile model: ones'-complement sign/magnitude product, registered reads.
  logic [7:0] mem [16];

  function automatic logic [15:0] tile_mul(input logic [7:0] a,
                                           input logic [7:0] b);
    logic [7:0]  ma;
    logic [7:0]  mb;
    logic [15:0] p;
    ma = a[7] ? ~a : a;
    mb = b[7] ? ~b : b;
    p  = 16'(ma) * 16'(mb);
    return (a[7] ^ b[7]) ? ~p : p;
  endfunction

  always @(posedge clk) begin
    logic [15:0] p;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      dut_uo <= 8'h00;
    end else begin
      p = tile_mul(mem[0], mem[1]);
      mem[14] <= p[7:0];
      mem[15] <= p[15:8];
      if (!dut_ui[4]) begin
        if (dut_ui[7]) mem[dut_ui[3:0]] <= dut_uio;
        dut_uo <= mem[dut_ui[3:0]];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'h0);
    check({tag, "_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_rsp"},   32'(rsp_r),     32'h0);
    check({tag, "_ops"},   32'(op_count),  32'h0);
    check({tag, "_ui"},    32'(dut_ui),    32'h10);
    check({tag, "_uio"},   32'(dut_uio),   32'h0);
  endtask

  task automatic wait_ready(input string tag);
    int g = 0;
    while (!req_ready && g < 60) begin
      tick();
      g++;
    end
    if (!req_ready) check({tag, "_ready_timeout"}, 32'(req_ready), 32'h1);
  endtask

  task automatic handshake(input string tag);
    int g = 0;
    logic [15:0] e;
    logic [15:0] ops0;
    while (!rsp_valid && g < 60) begin
      tick();
      g++;
    end
    if (!rsp_valid) begin
      check({tag, "_valid_timeout"}, 32'(rsp_valid), 32'h1);
    end else begin
      rsp_ready = 1'b1;
      e = exp_q.pop_front();
      ops0 = op_count;
      check({tag, "_rsp"}, 32'(rsp_r), 32'(e));
      tick();
      rsp_ready = 1'b0;
      check({tag, "_ops"}, 32'(op_count), 32'(ops0 + 16'd1));
      check({tag, "_valid_drop"}, 32'(rsp_valid), 32'h0);
    end
  endtask

  task automatic start(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] e, input string tag);
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    wait_ready(tag);
    exp_q.push_back(e);
    tick();
    req_valid = 1'b0;
  endtask

  logic [7:0] bus [6];

  initial begin
    bus = '{8'h80, 8'h81, 8'h10, 8'h0E, 8'h0F, 8'h10};
    rst_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_a = 8'h00;
    req_b = 8'h00;
    repeat (3) tick();
    check_reset_vals("reset");

    rst_n = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      check($sformatf("warm%0d_ready", c), 32'(req_ready),
            (c >= 8) ? 32'h1 : 32'h0);
      check($sformatf("warm%0d_ui", c), 32'(dut_ui), 32'h10);
      check($sformatf("warm%0d_valid", c), 32'(rsp_valid), 32'h0);
      if (c < 8) tick();
    end

    start(8'h03, 8'h05, 16'h000F, "small");
    for (int k = 0; k < 6; k++) begin
      check($sformatf("small_bus%0d", k), 32'(dut_ui), 32'(bus[k]));
      check($sformatf("small_vld%0d", k), 32'(rsp_valid), 32'h0);
      tick();
    end
    check("small_latency", 32'(rsp_valid), 32'h1);
    handshake("small");

    start(8'd100, 8'd100, 16'h2710, "trunc");
    handshake("trunc");

    start(8'hFF, 8'h05, 16'hFFFF, "sign");
    handshake("sign");

    start(8'h02, 8'h04, 16'h0008, "bp");
    begin
      int g = 0;
      while (!rsp_valid && g < 60) begin
        tick();
        g++;
      end
    end
    for (int k = 0; k < 20; k++) begin
      req_valid = k[0];
      req_a = 8'(k * 3);
      req_b = 8'(k + 7);
      check($sformatf("bp%0d_rsp", k), 32'(rsp_r), 32'h0008);
      check($sformatf("bp%0d_ready", k), 32'(req_ready), 32'h0);
      check($sformatf("bp%0d_ui", k), 32'(dut_ui), 32'h10);
      check($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'h1);
      tick();
    end
    req_valid = 1'b1;
    req_a = 8'h11;
    req_b = 8'h22;
    check("bp_hs_ready", 32'(req_ready), 32'h0);
    handshake("bp");
    check("bp_ready_back", 32'(req_ready), 32'h1);
    req_valid = 1'b0;
    tick();
    check("bp_no_accept_ui", 32'(dut_ui), 32'h10);
    check("bp_one_hs", 32'(op_count), 32'h4);

    start(8'h03, 8'h05, 16'h000F, "midrst");
    void'(exp_q.pop_back());
    repeat (3) tick();
    check("midrst_in_rdlo", 32'(dut_ui), 32'h0E);
    rst_n = 1'b0;
    tick();
    check_reset_vals("midrst");
    rst_n = 1'b1;
    start(8'h07, 8'h09, 16'h003F, "post");
    handshake("post");
    check("post_ops", 32'(op_count), 32'h1);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
